// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed 7-segment driver. BCD digits are captured into shadow
// registers and committed at frame start, then scanned out with blanking gaps.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter bit LZ_BLANK  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] data_0,
    input  logic [3:0] data_1,
    output logic [7:0] seg,
    output logic [1:0] sel,
    output logic       frame_done
);

    localparam int MAX_DWELL = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW        = $clog2(MAX_DWELL);

    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [7:0]    SEG_OFF    = 8'hFF;

    typedef enum logic [1:0] {
        DIG0   = 2'd0,
        BLANK0 = 2'd1,
        DIG1   = 2'd2,
        BLANK1 = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    sh0, sh1;
    logic [3:0]    dp0, dp1;
    logic          dwell_end;

    // Active-low segments {dp,g,f,e,d,c,b,a}; non-decimal codes show a dash.
    function automatic logic [7:0] enc(input logic [3:0] v);
        case (v)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    always_comb begin
        dwell_end = 1'b0;
        if (state == DIG0 || state == DIG1) dwell_end = (cnt == SCAN_LAST);
        else                                dwell_end = (cnt == BLANK_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh0 <= '0;
            sh1 <= '0;
        end else if (load) begin
            sh0 <= data_0;
            sh1 <= data_1;
        end
    end

    // Outputs are registered alongside the state so each phase is glitch-free;
    // the value for the new phase is computed on the edge that enters it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK1;
            cnt        <= '0;
            dp0        <= '0;
            dp1        <= '0;
            seg        <= SEG_OFF;
            sel        <= 2'b11;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!dwell_end) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
                case (state)
                    DIG0: begin
                        state <= BLANK0;
                        seg   <= SEG_OFF;
                        sel   <= 2'b11;
                    end
                    BLANK0: begin
                        state <= DIG1;
                        seg   <= (LZ_BLANK && dp1 == 4'd0) ? SEG_OFF : enc(dp1);
                        sel   <= 2'b01;
                    end
                    DIG1: begin
                        state <= BLANK1;
                        seg   <= SEG_OFF;
                        sel   <= 2'b11;
                    end
                    default: begin
                        // Frame start: commit shadows; a load on this same edge
                        // lands in the shadows only and shows next frame.
                        state      <= DIG0;
                        dp0        <= sh0;
                        dp1        <= sh1;
                        seg        <= enc(sh0);
                        sel        <= 2'b10;
                        frame_done <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
